multicycle_ctrl: RTL and testbench

- Multi-cycle sequencing FSM for the 32-bit MIPS datapath.
- Lets one shared instruction/data memory port, one ALU and the register file be reused across FETCH/DECODE/EXEC/MEM/WB steps.
- Drives every datapath mux/enable and waits on a memory ready handshake; illegal opcodes and memory timeouts go to a sticky TRAP.
- Sits between the instruction register (opcode/funct), the ALU zero flag and the memory port.

---
 rtl/multicycle_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for a 32-bit MIPS datapath: steps one shared
// memory port, ALU and register file through fetch/decode/execute/memory/writeback.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [3:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Last wait cycle index: mem_ready still low here means the access timed out.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             trap_q, trap_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             in_wait;
    logic             timeout_hit;
    logic             retire;
    logic             unused_ok;

    // funct is decoded by ALU control and zero gates PC load in the datapath.
    assign unused_ok = ^{funct, zero};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        in_wait     = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        timeout_hit = in_wait && !mem_ready && (wait_cnt_q == WAIT_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)        state_d = S_DECODE;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)        state_d = S_MEMWB;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_MEMWB: state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_ready)        state_d = S_FETCH;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            // Branch outputs are unconditional; the datapath ANDs pc_write_cond with zero.
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        retire = (state_q == S_MEMWB)  || (state_q == S_RWB)  ||
                 (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                 (state_q == S_ADDIWB) || ((state_q == S_MEMWR) && mem_ready);
        // Staying in a wait state only happens with mem_ready low; any transition clears.
        wait_cnt_d = (in_wait && (state_d == state_q)) ? wait_cnt_q + 8'd1 : 8'd0;
        trap_d     = trap_q || (state_d == S_TRAP);
        retired_d  = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q <= 8'd0;
            trap_q     <= 1'b0;
            retired_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            trap_q     <= trap_d;
            retired_q  <= retired_d;
        end
    end

    assign state   = state_q;
    assign trap    = trap_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// expected state/step list from the opcode and planned memory wait lengths.
module tb_multicycle_ctrl;

    localparam int TO    = 16;
    localparam int CNT_W = 32;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_RWB = 4'd7,
                           S_BRANCH = 4'd8, S_JUMP = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                           S_TRAP = 4'd15;
    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04,
                           OP_J = 6'h02, OP_ADDI = 6'h08;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [5:0]       opcode = '0;
    logic [5:0]       funct = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]       pc_src, alu_src_b, alu_op;
    logic             alu_src_a, reg_dst, mem_to_reg, reg_write, trap;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .state(state), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       reg_dst, mem_to_reg, reg_write, trap;
    } ctl_t;

    ctl_t obs;
    assign obs = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, trap};

    typedef struct {
        logic [3:0] st;
        logic       rdy;
    } step_t;

    step_t       q[$];
    int unsigned exp_ret = 0;
    int          errs = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Control word each state must present.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic rdy);
        ctl_t c = '0;
        case (st)
            S_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_MEMRD:  begin c.mem_read = 1; c.iord = 1; end
            S_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            S_MEMWR:  begin c.mem_write = 1; c.iord = 1; end
            S_EXEC:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            S_RWB:    begin c.reg_write = 1; c.reg_dst = 1; end
            S_BRANCH: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_src = 2'b01; end
            S_JUMP:   begin c.pc_write = 1; c.pc_src = 2'b10; end
            S_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_ADDIWB: c.reg_write = 1;
            S_TRAP:   c.trap = 1;
            default:  ;
        endcase
        return c;
    endfunction

    function automatic void push(input logic [3:0] st, input logic rdy);
        step_t s;
        s.st  = st;
        s.rdy = rdy;
        q.push_back(s);
    endfunction

    // w idle cycles then ready; w >= TO means the access never completes.
    function automatic void push_wait(input logic [3:0] st, input int w, output bit to);
        int n0 = (w >= TO) ? TO : w;
        for (int i = 0; i < n0; i++) push(st, 1'b0);
        to = (w >= TO);
        if (!to) push(st, 1'b1);
    endfunction

    task automatic do_reset_check();
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'($urandom);
        @(posedge clk);
        #1;
        exp_ret = 0;
        check("rst_state", state, S_FETCH);
        check("rst_trap", trap, 0);
        check("rst_retired", retired, 0);
        rst = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input logic z, input int abort_at);
        bit to;
        bit trapped;
        trapped = 0;
        q.delete();
        push_wait(S_FETCH, fw, to);
        if (to) trapped = 1;
        else begin
            push(S_DECODE, 1'($urandom));
            case (op)
                OP_R:    begin push(S_EXEC, 1'($urandom)); push(S_RWB, 1'($urandom)); end
                OP_LW:   begin
                    push(S_MEMADR, 1'($urandom));
                    push_wait(S_MEMRD, mw, to);
                    if (to) trapped = 1; else push(S_MEMWB, 1'($urandom));
                end
                OP_SW:   begin push(S_MEMADR, 1'($urandom)); push_wait(S_MEMWR, mw, to); trapped = to; end
                OP_BEQ:  push(S_BRANCH, 1'($urandom));
                OP_J:    push(S_JUMP, 1'($urandom));
                OP_ADDI: begin push(S_ADDIEX, 1'($urandom)); push(S_ADDIWB, 1'($urandom)); end
                default: trapped = 1;
            endcase
        end
        foreach (q[i]) begin
            @(negedge clk);
            opcode    = (q[i].st == S_FETCH) ? 6'($urandom) : op;
            funct     = 6'($urandom);
            zero      = z;
            mem_ready = q[i].rdy;
            if (i == abort_at) begin
                rst       = 1'b0;
                mem_ready = 1'b1;
            end
            #1;
            check("state", state, q[i].st);
            check("ctl", obs, exp_ctl(q[i].st, mem_ready));
            check("retired", retired, exp_ret);
            if (i == abort_at) begin
                @(posedge clk);
                #1;
                exp_ret = 0;
                check("abort_state", state, S_FETCH);
                check("abort_mem_write", mem_write, 0);
                check("abort_retired", retired, 0);
                rst = 1'b1;
                return;
            end
        end
        if (trapped) begin
            repeat (3) begin
                @(negedge clk);
                opcode    = 6'($urandom);
                mem_ready = 1'($urandom);
                #1;
                check("trap_state", state, S_TRAP);
                check("trap_ctl", obs, exp_ctl(S_TRAP, mem_ready));
                check("trap_retired", retired, exp_ret);
            end
            do_reset_check();
        end else begin
            exp_ret++;
        end
    endtask

    function automatic int pick_wait();
        int r = int'($urandom_range(0, 19));
        if (r == 0) return TO;
        if (r == 1) return TO - 1;
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [5:0] ops[6];
        logic [5:0] op;
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
        ops[3] = OP_BEQ; ops[4] = OP_J; ops[5] = OP_ADDI;

        rst       = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", state, S_FETCH);
        check("reset_trap", trap, 0);
        check("reset_retired", retired, 0);
        check("reset_ctl", obs, exp_ctl(S_FETCH, mem_ready));
        rst = 1'b1;

        run_instr(OP_R, 0, 0, 1'b0, -1);
        run_instr(OP_R, 0, 0, 1'b1, -1);
        run_instr(OP_LW, 0, 3, 1'b0, -1);
        run_instr(OP_SW, 1, 2, 1'b0, -1);
        run_instr(OP_BEQ, 0, 0, 1'b1, -1);
        run_instr(OP_BEQ, 0, 0, 1'b0, -1);
        run_instr(OP_J, 0, 0, 1'b0, -1);
        run_instr(OP_ADDI, 2, 0, 1'b0, -1);
        run_instr(OP_R, TO - 1, 0, 1'b0, -1);
        run_instr(OP_LW, 0, TO - 1, 1'b0, -1);
        run_instr(6'h3F, 0, 0, 1'b0, -1);
        run_instr(OP_R, TO, 0, 1'b0, -1);
        run_instr(OP_R, 0, 0, 1'b0, -1);
        run_instr(OP_SW, 0, TO, 1'b0, -1);
        run_instr(OP_J, 0, 0, 1'b0, -1);
        run_instr(OP_SW, 0, 5, 1'b0, 5);
        run_instr(OP_ADDI, 0, 0, 1'b0, -1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                do op = 6'($urandom);
                while (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, pick_wait(), pick_wait(), 1'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        errs++;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errs, checks);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
